arith_rr_scheduler: RTL and testbench

//  Shares one combinational 8-bit signed Arith datapath (op 00 add, 01 sub, 10 mul, 11 zero)

---
 rtl/arith_rr_scheduler.sv | 179 +++++++++++++++++
 tb/tb_arith_rr_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_rr_scheduler.sv
// arith_rr_scheduler: round-robin front end sharing one 8-bit signed add/sub/mul datapath
// between NREQ requesters. Each accepted op takes IDLE -> EXEC -> RESP and is returned on a
// single response channel tagged with the requester id.
// Optional feature: define ARITH_STICKY_OV_EN for per-requester sticky overflow status.
module arith_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_op1,
    input  logic [8*NREQ-1:0]   req_op2,
    input  logic [2*NREQ-1:0]   req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_result,
    output logic                rsp_ov,
    input  logic [NREQ-1:0]     ov_clr,
    output logic [NREQ-1:0]     ov_status
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [7:0]      op1_q, op1_d, op2_q, op2_d;
    logic [1:0]      op_q, op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_result_q, rsp_result_d;
    logic            rsp_ov_q, rsp_ov_d;
    logic [NREQ-1:0] ov_status_q, ov_status_d;

    logic [NREQ-1:0] grant;
    logic            found;
    logic [IDW-1:0]  win;
    logic [7:0]      sel_op1, sel_op2;
    logic [1:0]      sel_op;

    logic signed [15:0] a16, b16, full;
    logic               arith_ov;
    logic [7:0]         arith_res;

    // Round-robin search starting just after the last winner; only active in IDLE.
    always_comb begin
        int unsigned idx;
        grant   = '0;
        found   = 1'b0;
        win     = ptr_q;
        sel_op1 = '0;
        sel_op2 = '0;
        sel_op  = '0;
        idx     = 0;
        if (state_q == StIdle) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                idx = (32'(ptr_q) + k) % NREQ;
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (!found && (j == idx) && req_valid[j]) begin
                        found   = 1'b1;
                        win     = IDW'(j);
                        sel_op1 = req_op1[8*j +: 8];
                        sel_op2 = req_op2[8*j +: 8];
                        sel_op  = req_op[2*j +: 2];
                    end
                end
            end
        end
        if (found) grant[win] = 1'b1;
    end

    // Reset forces the grant low even though the FSM sits in IDLE.
    assign req_ready = rst ? grant : '0;

    // Shared datapath: 16-bit signed intermediate, saturate-to-zero on 8-bit overflow.
    always_comb begin
        a16 = {{8{op1_q[7]}}, op1_q};
        b16 = {{8{op2_q[7]}}, op2_q};
        unique case (op_q)
            2'b00:   full = a16 + b16;
            2'b01:   full = a16 - b16;
            2'b10:   full = a16 * b16;
            default: full = '0;
        endcase
        arith_ov  = (full > 16'sd127) || (full < -16'sd128);
        arith_res = arith_ov ? 8'd0 : full[7:0];
    end

    // FSM next-state, operand capture, response and sticky-status update.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ov_d     = rsp_ov_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    op1_d   = sel_op1;
                    op2_d   = sel_op2;
                    op_d    = sel_op;
                    id_d    = win;
                    ptr_d   = win;
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_result_d = arith_res;
                rsp_ov_d     = arith_ov;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef ARITH_STICKY_OV_EN
        // Clear first so a coincident set wins.
        ov_status_d = ov_status_q & ~ov_clr;
        if ((state_q == StExec) && arith_ov) ov_status_d[id_q] = 1'b1;
`else
        ov_status_d = '0;
`endif
    end

`ifndef ARITH_STICKY_OV_EN
    logic unused_ov_clr;
    assign unused_ov_clr = ^ov_clr;
`endif

    // State and registered outputs; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            ptr_q        <= IDW'(NREQ - 1);
            id_q         <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_ov_q     <= 1'b0;
            ov_status_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ov_q     <= rsp_ov_d;
            ov_status_q  <= ov_status_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ov     = rsp_ov_q;
    assign ov_status  = ov_status_q;

endmodule

// File: tb/tb_arith_rr_scheduler.sv
// Scoreboard bench for arith_rr_scheduler: directed cases plus randomized traffic, checked
// against a round-robin / arithmetic reference model.
module tb_arith_rr_scheduler;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [8*N-1:0] req_op1 = '0;
    logic [8*N-1:0] req_op2 = '0;
    logic [2*N-1:0] req_op = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [7:0]   rsp_result;
    logic         rsp_ov;
    logic [N-1:0] ov_clr = '0;
    logic [N-1:0] ov_status;

    arith_rr_scheduler #(.NREQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ov     (rsp_ov),
        .ov_clr     (ov_clr),
        .ov_status  (ov_status)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int res;
        bit ov;
        int due;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    int m_ptr = N - 1;
    bit m_busy = 0;
    int m_gcyc = 0;
    bit granted_now = 0;
    int grant_log[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void arith_model(input int op, input int a, input int b,
                                        output int res, output bit ov);
        int full;
        case (op)
            0: full = a + b;
            1: full = a - b;
            2: full = a * b;
            default: full = 0;
        endcase
        ov  = (full > 127) || (full < -128);
        res = ov ? 0 : full;
    endfunction

    // Expected grant from the current inputs; on a grant, queue the expected response.
    task automatic cycle_check();
        int exp_g;
        int a, b, op, res;
        bit ov;
        exp_g = -1;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (exp_g < 0 && req_valid[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
            end
        end
        check("req_ready", int'(req_ready), (exp_g >= 0) ? (1 << exp_g) : 0);
`ifndef ARITH_STICKY_OV_EN
        check("ov_status_tied", int'(ov_status), 0);
`endif
        granted_now = 0;
        if (exp_g >= 0) begin
            a  = $signed(req_op1[8*exp_g +: 8]);
            b  = $signed(req_op2[8*exp_g +: 8]);
            op = int'(req_op[2*exp_g +: 2]);
            arith_model(op, a, b, res, ov);
            sbq.push_back('{exp_g, res, ov, cyc + 2});
            grant_log.push_back(exp_g);
            m_ptr = exp_g;
            m_busy = 1;
            m_gcyc = cyc;
            granted_now = 1;
        end else if (m_busy && cyc >= m_gcyc + 2 && rsp_ready) begin
            m_busy = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int op, input int a, input int b);
        req_op1[8*r +: 8] = 8'(a);
        req_op2[8*r +: 8] = 8'(b);
        req_op[2*r +: 2]  = 2'(op);
        req_valid[r]      = 1'b1;
    endtask

    task automatic run_op(input int r, input int op, input int a, input int b);
        bit got;
        got = 0;
        req_valid = '0;
        set_req(r, op, a, b);
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = granted_now;
        end
        check("grant_seen", int'(got), 1);
        req_valid = '0;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        sbq.delete();
        m_ptr = N - 1;
        m_busy = 0;
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_rsp_result", int'(rsp_result), 0);
        check("rst_rsp_ov", int'(rsp_ov), 0);
        check("rst_ov_status", int'(ov_status), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        bit in_rsp;
        int r;
        in_rsp = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_rsp = 0;
            end else if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    r = $signed(rsp_result);
                    if (!in_rsp) check("rsp_latency", cyc, sbq[0].due);
                    check("rsp_id", int'(rsp_id), sbq[0].id);
                    check("rsp_result", r, sbq[0].res);
                    check("rsp_ov", int'(rsp_ov), int'(sbq[0].ov));
                    if (rsp_ready) begin
                        void'(sbq.pop_front());
                        in_rsp = 0;
                    end else begin
                        in_rsp = 1;
                    end
                end
            end else if (sbq.size() > 0 && !in_rsp && cyc > sbq[0].due) begin
                check("rsp_missing", 0, 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        @(posedge clk);
        #1;
        do_reset();

        // Directed arithmetic
        run_op(1, 0, 100, 27);
        run_op(2, 0, 100, 28);
        run_op(2, 1, -128, 1);
        run_op(2, 2, 12, -10);
        run_op(2, 2, 16, 8);
        run_op(2, 3, 55, 66);
        run_op(0, 1, -100, 28);

        // Stall in RESP for 5 cycles, then a follow-on grant
        rsp_ready = 1'b0;
        req_valid = '0;
        set_req(3, 2, -9, 14);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = granted_now;
        end
        check("stall_grant", int'(got), 1);
        req_valid = '0;
        set_req(0, 0, 7, 8);
        repeat (6) tick();
        rsp_ready = 1'b1;
        repeat (6) tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset during EXEC, then all requesters active
        req_valid = '1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = granted_now;
        end
        check("pre_reset_grant", int'(got), 1);
        do_reset();
        grant_log.delete();
        repeat (18) tick();
        for (int i = 0; i < 6; i++) begin
            check("rr_order", (grant_log.size() > i) ? grant_log[i] : -1, exp_order[i]);
        end
        req_valid = '0;
        repeat (4) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_op1[8*r +: 8] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
                req_op2[8*r +: 8] = ($urandom_range(0, 3) == 0) ? 8'h7f : 8'($urandom);
                req_op[2*r +: 2]  = 2'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifndef ARITH_STICKY_OV_EN
            ov_clr = N'($urandom);
`endif
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        ov_clr = '0;
        repeat (6) tick();

`ifdef ARITH_STICKY_OV_EN
        do_reset();
        run_op(2, 0, 100, 100);
        check("sticky_set", int'(ov_status), 4);
        repeat (3) tick();
        check("sticky_hold", int'(ov_status), 4);
        req_valid = '0;
        set_req(2, 2, 50, 50);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = granted_now;
        end
        check("sticky_grant", int'(got), 1);
        req_valid = '0;
        ov_clr = 4'b0100;
        tick();
        ov_clr = '0;
        check("sticky_set_wins", int'(ov_status), 4);
        repeat (4) tick();
        ov_clr = 4'b0100;
        tick();
        ov_clr = '0;
        check("sticky_clear", int'(ov_status), 0);
`endif

        check("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
